// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the low-speed USB receive controller.
package usb_rx_pkg;

  // Receive controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SYNC     = 2'd1,
    DATA     = 2'd2,
    EOP_WAIT = 2'd3
  } rx_state_t;

  // 48 MHz clock / 1.5 Mbps line rate.
  localparam int CLKS_PER_BIT       = 32;
  localparam int BITS_PER_BYTE      = 8;

  // Parameter defaults for usb_rx_ctrl.
  localparam int SYNC_MIN_ZEROS_DEF = 6;
  localparam int MAX_BYTES_DEF      = 11;

endpackage

// File: rtl/usb_rx_byte_assembler.sv
// Shift register and bit counter that assemble received bits LSB-first.
// byte_done is combinational: it flags that the shift happening this cycle
// completes a byte, and byte_next is that completed byte.
module usb_rx_byte_assembler
  import usb_rx_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     clear,
  input  logic                     bit_in,
  output logic [BITS_PER_BYTE-1:0] byte_next,
  output logic [2:0]               bit_cnt,
  output logic                     byte_done
);

  logic [BITS_PER_BYTE-1:0] shreg;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  assign byte_next = {bit_in, shreg[BITS_PER_BYTE-1:1]};
  assign byte_done = shift_en && (bit_cnt == 3'd7);

  // Shift register and wrapping bit counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= byte_next;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive-side packet controller: SYNC hunt, byte framing and EOP handling.
// Output handshake: rx_valid and rx_done are single-cycle strobes with no
// back-pressure; the consumer must take rx_data in the cycle rx_valid=1
// (rx_data then holds until the next byte), and must read rx_error only in
// the cycle rx_done=1. dbg_state mirrors the FSM state for observation.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
  parameter int MAX_BYTES      = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  input  logic       rx_bit,
  input  logic       bit_stuffed,
  input  logic       line_j,
  input  logic       rx_eop,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       rx_error,
  output rx_state_t  dbg_state
);

  localparam int             BCW       = $clog2(MAX_BYTES + 1);
  localparam logic [BCW-1:0] MAX_CNT   = BCW'(MAX_BYTES);
  localparam logic [2:0]     MIN_ZEROS = 3'(SYNC_MIN_ZEROS);

  rx_state_t      state;
  logic [2:0]     zero_cnt;
  logic [BCW-1:0] byte_cnt;
  logic           overflow;
  logic           rx_eop_q;
  logic           eop_edge;
  logic           shift_en;
  logic           clear;
  logic           byte_done;
  logic [2:0]     bit_cnt;
  logic [7:0]     byte_next;

  // EOP acts only on its rising edge; a simultaneous bit is discarded.
  assign eop_edge  = rx_eop & ~rx_eop_q;
  assign shift_en  = (state == DATA) & pulse & ~bit_stuffed & ~eop_edge;
  assign clear     = (state == SYNC) & pulse & rx_bit & ~eop_edge &
                     (zero_cnt >= MIN_ZEROS);
  assign dbg_state = state;

  usb_rx_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .clear     (clear),
    .bit_in    (rx_bit),
    .byte_next (byte_next),
    .bit_cnt   (bit_cnt),
    .byte_done (byte_done)
  );

  // Register rx_eop once for edge detection.
  always_ff @(posedge clk) begin
    if (rst) rx_eop_q <= 1'b0;
    else     rx_eop_q <= rx_eop;
  end

  // Packet FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      zero_cnt  <= '0;
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      rx_active <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_done   <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_done  <= 1'b0;
      rx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (pulse && !rx_bit) begin
            zero_cnt <= 3'd1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (eop_edge) begin
            state <= IDLE;
          end else if (pulse) begin
            if (!rx_bit) begin
              if (zero_cnt != 3'd7) zero_cnt <= zero_cnt + 3'd1;
            end else if (zero_cnt >= MIN_ZEROS) begin
              state     <= DATA;
              rx_active <= 1'b1;
              byte_cnt  <= '0;
              overflow  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (eop_edge) begin
            state     <= EOP_WAIT;
            rx_active <= 1'b0;
            rx_done   <= 1'b1;
            rx_error  <= (bit_cnt != 3'd0) || (byte_cnt == '0) || overflow;
          end else if (byte_done) begin
            if (byte_cnt == MAX_CNT) begin
              overflow <= 1'b1;
            end else begin
              rx_data  <= byte_next;
              rx_valid <= 1'b1;
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        EOP_WAIT: begin
          if (pulse && line_j) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Bench for usb_rx_ctrl: packet-level stimulus, a behavioural packet model
// producing cycle-by-cycle expected outputs, and a byte scoreboard.
module tb_usb_rx_ctrl;
  import usb_rx_pkg::*;

  localparam int GAP  = 7;   // idle clocks between bit strobes
  localparam int MAXB = 11;
  localparam int MINZ = 6;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic       rx_bit;
  logic       bit_stuffed;
  logic       line_j;
  logic       rx_eop;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_done;
  logic       rx_error;
  rx_state_t  dbg_state;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] pkt_q[$];
  int         done_cnt = 0;
  logic       last_err = 1'b0;
  int         ones_run = 0;

  // Behavioural model: 0 = waiting for a zero, 1 = counting SYNC zeros,
  // 2 = collecting packet bits, 3 = waiting for the line to return to J.
  int         m_mode     = 0;
  int         m_zeros    = 0;
  logic       m_bits[$];
  int         m_nbytes   = 0;
  logic       m_ovf      = 1'b0;
  logic       m_eop_prev = 1'b0;
  logic       exp_active = 1'b0;
  logic       exp_valid  = 1'b0;
  logic [7:0] exp_data   = 8'h00;
  logic       exp_done   = 1'b0;
  logic       exp_error  = 1'b0;

  usb_rx_ctrl #(
    .SYNC_MIN_ZEROS (MINZ),
    .MAX_BYTES      (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse       (pulse),
    .rx_bit      (rx_bit),
    .bit_stuffed (bit_stuffed),
    .line_j      (line_j),
    .rx_eop      (rx_eop),
    .rx_active   (rx_active),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_done     (rx_done),
    .rx_error    (rx_error),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Model: what the outputs must be after this clock edge.
  task automatic model_step();
    logic       ev;
    logic [7:0] b;
    if (rst) begin
      m_mode = 0; m_zeros = 0; m_bits.delete(); m_nbytes = 0; m_ovf = 1'b0;
      m_eop_prev = 1'b0;
      exp_active = 1'b0; exp_valid = 1'b0; exp_data = 8'h00;
      exp_done = 1'b0; exp_error = 1'b0;
      return;
    end
    exp_valid = 1'b0; exp_done = 1'b0; exp_error = 1'b0;
    ev = rx_eop && !m_eop_prev;
    m_eop_prev = rx_eop;
    case (m_mode)
      0: if (pulse && !rx_bit) begin m_zeros = 1; m_mode = 1; end
      1: begin
        if (ev) m_mode = 0;
        else if (pulse) begin
          if (!rx_bit) m_zeros = (m_zeros < 7) ? m_zeros + 1 : 7;
          else if (m_zeros >= MINZ) begin
            m_mode = 2; exp_active = 1'b1;
            m_bits.delete(); m_nbytes = 0; m_ovf = 1'b0;
          end else m_mode = 0;
        end
      end
      2: begin
        if (ev) begin
          m_mode = 3; exp_active = 1'b0; exp_done = 1'b1;
          exp_error = (m_bits.size() != 0) || (m_nbytes == 0) || m_ovf;
        end else if (pulse && !bit_stuffed) begin
          m_bits.push_back(rx_bit);
          if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) b[i] = m_bits[i];
            m_bits.delete();
            if (m_nbytes == MAXB) m_ovf = 1'b1;
            else begin
              exp_data = b; exp_valid = 1'b1; m_nbytes++;
            end
          end
        end
      end
      default: if (pulse && line_j) m_mode = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: outputs against the model, bytes against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("outputs", 32'({rx_active, rx_valid, rx_data, rx_done, rx_error}),
            32'({exp_active, exp_valid, exp_data, exp_done, exp_error}));
      check("valid_done_apart", 32'(rx_valid & rx_done), 32'd0);
      if (rx_valid) begin
        cap_q.push_back(rx_data);
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("byte", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (rx_done) begin
        done_cnt++;
        last_err = rx_error;
      end
    end
  end

  // Driver tasks
  task automatic pulse_bit(input logic b, input logic st, input logic lj, input logic eop);
    repeat (GAP) @(negedge clk);
    pulse = 1'b1; rx_bit = b; bit_stuffed = st; line_j = lj;
    if (eop) rx_eop = 1'b1;
    @(negedge clk);
    pulse = 1'b0; bit_stuffed = 1'b0;
  endtask

  task automatic idle_ones(input int n);
    for (int i = 0; i < n; i++) pulse_bit(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_sync(input int nz);
    for (int i = 0; i < nz; i++) pulse_bit(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_bit(1'b1, 1'b0, 1'b0, 1'b0);
    ones_run = 1;
  endtask

  // One data bit, followed by a stuffed bit after six consecutive ones.
  task automatic send_data_bit(input logic b, input logic eop);
    pulse_bit(b, 1'b0, 1'b0, eop);
    if (b) ones_run++; else ones_run = 0;
    if (ones_run == 6 && !eop) begin
      pulse_bit(1'b0, 1'b1, 1'b0, 1'b0);
      ones_run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic eop_last);
    for (int i = 0; i < 8; i++) send_data_bit(b[i], eop_last && (i == 7));
  endtask

  task automatic send_eop();
    repeat (GAP) @(negedge clk);
    rx_eop = 1'b1;
    repeat (3) @(negedge clk);
    rx_eop = 1'b0;
  endtask

  task automatic back_to_idle();
    pulse_bit(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_bit(1'b1, 1'b0, 1'b1, 1'b0);
    idle_ones(1);
  endtask

  // Full packet from pkt_q; eop_last makes EOP coincide with the last bit.
  task automatic run_packet(input int nz, input int extra, input logic eop_last);
    int   n;
    int   nfull;
    logic exp_err;
    n       = pkt_q.size();
    nfull   = eop_last ? n - 1 : n;
    exp_err = eop_last || (extra != 0) || (nfull == 0) || (nfull > MAXB);
    cap_q.delete();
    done_cnt = 0;
    for (int i = 0; i < nfull && i < MAXB; i++) exp_q.push_back(pkt_q[i]);
    idle_ones(2);
    send_sync(nz);
    for (int i = 0; i < n; i++) send_byte(pkt_q[i], eop_last && (i == n - 1));
    for (int i = 0; i < extra; i++) send_data_bit(1'($urandom_range(0, 1)), 1'b0);
    if (!eop_last) send_eop();
    else begin
      repeat (2) @(negedge clk);
      rx_eop = 1'b0;
    end
    back_to_idle();
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_error", 32'(last_err), 32'(exp_err));
    check("bytes_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int extra;
    logic eop_last;

    rst = 1'b1; pulse = 1'b0; rx_bit = 1'b1; bit_stuffed = 1'b0;
    line_j = 1'b1; rx_eop = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", 32'({rx_active, rx_valid, rx_data, rx_done, rx_error}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    idle_ones(3);

    // Nominal packet
    pkt_q = '{8'hC3, 8'hA5};
    run_packet(7, 0, 1'b0);
    check("nominal_count", 32'(cap_q.size()), 32'd2);
    check("nominal_b0", 32'(cap_q[0]), 32'hC3);
    check("nominal_b1", 32'(cap_q[1]), 32'hA5);
    check("nominal_err", 32'(last_err), 32'd0);

    // Stuffed bits inside runs of ones
    pkt_q = '{8'hFF, 8'h7E, 8'hFF};
    run_packet(6, 0, 1'b0);
    check("stuff_b0", 32'(cap_q[0]), 32'hFF);
    check("stuff_b1", 32'(cap_q[1]), 32'h7E);
    check("stuff_err", 32'(last_err), 32'd0);

    // Short SYNC, then a valid one
    done_cnt = 0;
    idle_ones(2);
    for (int i = 0; i < 4; i++) pulse_bit(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_bit(1'b1, 1'b0, 1'b0, 1'b0);
    idle_ones(2);
    check("short_sync_active", 32'(rx_active), 32'd0);
    check("short_sync_done", 32'(done_cnt), 32'd0);
    pkt_q = '{8'h5A};
    run_packet(8, 0, 1'b0);
    check("after_short_b0", 32'(cap_q[0]), 32'h5A);

    // Partial byte at EOP
    pkt_q = '{8'h2D};
    run_packet(7, 3, 1'b0);
    check("partial_count", 32'(cap_q.size()), 32'd1);
    check("partial_b0", 32'(cap_q[0]), 32'h2D);
    check("partial_err", 32'(last_err), 32'd1);

    // Overflow: 12 bytes with an 11-byte limit
    pkt_q.delete();
    for (int i = 0; i < 12; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    run_packet(7, 0, 1'b0);
    check("overflow_count", 32'(cap_q.size()), 32'd11);
    check("overflow_err", 32'(last_err), 32'd1);

    // EOP on the 8th bit of the last byte
    pkt_q = '{8'h11, 8'h22};
    run_packet(6, 0, 1'b1);
    check("eop_on_bit_count", 32'(cap_q.size()), 32'd1);
    check("eop_on_bit_b0", 32'(cap_q[0]), 32'h11);
    check("eop_on_bit_err", 32'(last_err), 32'd1);

    // Empty packet
    pkt_q.delete();
    run_packet(6, 0, 1'b0);
    check("empty_err", 32'(last_err), 32'd1);

    // Reset in the middle of DATA
    cap_q.delete();
    done_cnt = 0;
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h3C);
    idle_ones(2);
    send_sync(7);
    send_byte(8'h96, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_data_bit(1'b1, 1'b0);
    send_data_bit(1'b0, 1'b0);
    send_data_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_outputs", 32'({rx_active, rx_valid, rx_data, rx_done, rx_error}), 32'd0);
    idle_ones(4);
    check("mid_reset_done", 32'(done_cnt), 32'd0);
    check("mid_reset_bytes", 32'(cap_q.size()), 32'd2);
    exp_q.delete();

    // Randomized packets
    for (int k = 0; k < 12; k++) begin
      n        = $urandom_range(0, 12);
      eop_last = (n > 0) && ($urandom_range(0, 4) == 0);
      extra    = (!eop_last && $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
      run_packet($urandom_range(6, 9), extra, eop_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
